// File: rtl/fdiv.sv
// Single-precision divider y = x1 / x2 using iterative restoring mantissa division.
// Fixed latency of ITER cycles for every operand pair, including zero/denormal operands.
module fdiv #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        ready,
  output logic [31:0] y,
  output logic        valid
);

  localparam int unsigned ITER = 26 / BITS_PER_CYCLE;
  localparam int unsigned CW   = 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          sgn, sgn_nxt;
  logic [7:0]    e1, e1_nxt;
  logic [7:0]    e2, e2_nxt;
  logic [23:0]   dvs, dvs_nxt;
  logic [24:0]   rem, rem_nxt;
  logic [25:0]   quo, quo_nxt;
  logic [31:0]   y_nxt;

  logic [24:0]       rem_step;
  logic [25:0]       quo_step;
  logic [22:0]       mant;
  logic              guard;
  logic signed [9:0] ex;
  logic [23:0]       mant_rnd;
  logic [31:0]       packed_y;

  // Restoring steps: compare, conditionally subtract, then double the remainder.
  always_comb begin
    rem_step = rem;
    quo_step = quo;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (rem_step >= {1'b0, dvs}) begin
        rem_step = rem_step - {1'b0, dvs};
        quo_step = {quo_step[24:0], 1'b1};
      end else begin
        quo_step = {quo_step[24:0], 1'b0};
      end
      rem_step = {rem_step[23:0], 1'b0};
    end
  end

  // Normalise, round half up and pack the final quotient.
  always_comb begin
    if (quo_step[25]) begin
      mant  = quo_step[24:2];
      guard = quo_step[1];
      ex    = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
    end else begin
      mant  = quo_step[23:1];
      guard = quo_step[0];
      ex    = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd126;
    end
    mant_rnd = {1'b0, mant} + 24'(guard);
    if (mant_rnd[23]) begin
      mant = 23'd0;
      ex   = ex + 10'sd1;
    end else begin
      mant = mant_rnd[22:0];
    end
    if (e2 == 8'd0)          packed_y = {sgn, 8'hFF, 23'd0};
    else if (e1 == 8'd0)     packed_y = {sgn, 31'd0};
    else if (ex <= 10'sd0)   packed_y = {sgn, 31'd0};
    else if (ex >= 10'sd255) packed_y = {sgn, 8'hFF, 23'd0};
    else                     packed_y = {sgn, ex[7:0], mant};
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    sgn_nxt   = sgn;
    e1_nxt    = e1;
    e2_nxt    = e2;
    dvs_nxt   = dvs;
    rem_nxt   = rem;
    quo_nxt   = quo;
    y_nxt     = y;
    case (state)
      IDLE: begin
        if (ready) begin
          sgn_nxt   = x1[31] ^ x2[31];
          e1_nxt    = x1[30:23];
          e2_nxt    = x2[30:23];
          dvs_nxt   = {1'b1, x2[22:0]};
          rem_nxt   = {2'b01, x1[22:0]};
          quo_nxt   = 26'd0;
          count_nxt = '0;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (!ready) begin
          state_nxt = IDLE;
        end else begin
          rem_nxt   = rem_step;
          quo_nxt   = quo_step;
          count_nxt = count + CW'(1);
          if (count == CW'(ITER - 1)) begin
            y_nxt     = packed_y;
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      sgn   <= 1'b0;
      e1    <= 8'd0;
      e2    <= 8'd0;
      dvs   <= 24'd0;
      rem   <= 25'd0;
      quo   <= 26'd0;
      y     <= 32'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      sgn   <= sgn_nxt;
      e1    <= e1_nxt;
      e2    <= e2_nxt;
      dvs   <= dvs_nxt;
      rem   <= rem_nxt;
      quo   <= quo_nxt;
      y     <= y_nxt;
    end
  end

  // Strobe follows the requester so a dropped request never sees a result.
  assign valid = ready & (state == DONE);

endmodule
